// File: rtl/mem_access_unit_pkg.sv
// Shared memory-access types: bus transfer sizes, the request mode encoding and
// the FSM state type used by the memory access unit.
package mem_access_unit_pkg;

  typedef enum logic [2:0] {
    MSIZE_1B   = 3'd0,
    MSIZE_2B   = 3'd1,
    MSIZE_4B   = 3'd2,
    MSIZE_8B   = 3'd3,
    MSIZE_16B  = 3'd4,
    MSIZE_32B  = 3'd5,
    MSIZE_64B  = 3'd6,
    MSIZE_128B = 3'd7
  } msize_t;

  typedef struct packed {
    logic       store;
    logic       unsgn;
    logic [1:0] size;   // log2 of the access width in bytes
  } mem_mode_t;

  localparam mem_mode_t MODE_LB  = 4'b0000;
  localparam mem_mode_t MODE_LH  = 4'b0001;
  localparam mem_mode_t MODE_LW  = 4'b0010;
  localparam mem_mode_t MODE_LD  = 4'b0011;
  localparam mem_mode_t MODE_LBU = 4'b0100;
  localparam mem_mode_t MODE_LHU = 4'b0101;
  localparam mem_mode_t MODE_LWU = 4'b0110;
  localparam mem_mode_t MODE_SB  = 4'b1000;
  localparam mem_mode_t MODE_SH  = 4'b1001;
  localparam mem_mode_t MODE_SW  = 4'b1010;
  localparam mem_mode_t MODE_SD  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } mau_state_t;

  function automatic int unsigned mode_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

  // Unsigned stores, an unsigned full-width load, and anything wider than XLEN.
  function automatic logic mode_illegal(input mem_mode_t m, input int unsigned xlen_bytes);
    return (m.store && m.unsgn) ||
           (m.unsgn && m.size == 2'd3) ||
           (mode_bytes(m.size) > xlen_bytes);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-bus signals of the memory access unit. The master
// side is the pipeline plus memory; the slave side is the unit itself.
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BUS_BYTES = 8
) ();

  logic                   req_valid;
  logic                   req_ready;
  logic [XLEN-1:0]        req_addr;
  logic [XLEN-1:0]        req_wdata;
  mem_mode_t              req_mode;

  logic                   resp_valid;
  logic [XLEN-1:0]        resp_rdata;
  logic                   resp_misaligned;

  logic                   dbus_valid;
  logic [XLEN-1:0]        dbus_addr;
  msize_t                 dbus_size;
  logic [BUS_BYTES-1:0]   dbus_strobe;
  logic [8*BUS_BYTES-1:0] dbus_wdata;
  logic                   dbus_data_ok;
  logic [8*BUS_BYTES-1:0] dbus_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_mode, dbus_data_ok, dbus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           dbus_valid, dbus_addr, dbus_size, dbus_strobe, dbus_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_mode, dbus_data_ok, dbus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           dbus_valid, dbus_addr, dbus_size, dbus_strobe, dbus_wdata
  );

endinterface

// File: rtl/mau_lane_align.sv
// Combinational lane steering: shifts store data and byte strobes into a
// two-word window and extracts/extends load data from a two-word read pair.
module mau_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BUS_BYTES = 8,
  localparam int OFFW     = $clog2(BUS_BYTES),
  localparam int PAIR_W   = 16 * BUS_BYTES
) (
  input  logic [OFFW-1:0]        off,
  input  logic [1:0]             size,
  input  logic                   unsgn,
  input  logic [XLEN-1:0]        wdata,
  input  logic [PAIR_W-1:0]      rdata_pair,
  output logic [PAIR_W-1:0]      wide,
  output logic [2*BUS_BYTES-1:0] smask,
  output logic [XLEN-1:0]        load_data
);

  logic [XLEN-1:0]        data_mask;
  logic [2*BUS_BYTES-1:0] byte_mask;
  logic [PAIR_W-1:0]      shifted;
  logic [XLEN-1:0]        raw;
  logic                   msb;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    data_mask = '0;
    byte_mask = '0;
    for (int i = 0; i < XLEN / 8; i++) begin
      if (i < (1 << size)) begin
        data_mask[8*i +: 8] = 8'hFF;
        byte_mask[i]        = 1'b1;
      end
    end

    wide  = PAIR_W'(wdata & data_mask) << {off, 3'b000};
    smask = byte_mask << off;

    shifted = rdata_pair >> {off, 3'b000};
    raw     = shifted[XLEN-1:0] & data_mask;

    unique case (size)
      2'd0:    msb = raw[7];
      2'd1:    msb = raw[15];
      2'd2:    msb = raw[31];
      default: msb = raw[XLEN-1];
    endcase

    load_data = (unsgn || !msb) ? raw : (raw | ~data_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store unit between the MEM stage and the data bus: one
// request at a time, one or two bus beats, one response pulse.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN             = 64,
  parameter int BUS_BYTES        = 8,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input logic            clk,
  input logic            reset,
  mem_access_unit_if.slave bus
);

  localparam int OFFW  = $clog2(BUS_BYTES);
  localparam int BUS_W = 8 * BUS_BYTES;

  mau_state_t        state_q, state_d;
  logic              dvalid_q, dvalid_d;
  logic [XLEN-1:0]   addr_q, wdata_q;
  mem_mode_t         mode_q;
  logic              cross_q, mis_q;
  logic [BUS_W-1:0]  lo_q, hi_q;

  logic [OFFW-1:0]        req_off;
  logic                   req_cross, req_reject, accept, beat_done;
  logic [XLEN-1:0]        beat0_addr;
  logic [2*BUS_W-1:0]     wide;
  logic [2*BUS_BYTES-1:0] smask;
  logic [XLEN-1:0]        load_data;

  assign req_off    = bus.req_addr[OFFW-1:0];
  assign req_cross  = (int'(req_off) + int'(mode_bytes(bus.req_mode.size))) > BUS_BYTES;
  assign req_reject = mode_illegal(bus.req_mode, XLEN / 8) ||
                      (req_cross && !SPLIT_MISALIGNED);
  assign accept     = (state_q == ST_IDLE) && bus.req_valid;
  // dvalid_q is only ever high in a beat state, so this also ignores stray data_ok.
  assign beat_done  = dvalid_q && bus.dbus_data_ok;
  assign beat0_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};

  mau_lane_align #(
    .XLEN      (XLEN),
    .BUS_BYTES (BUS_BYTES)
  ) u_lane_align (
    .off        (addr_q[OFFW-1:0]),
    .size       (mode_q.size),
    .unsgn      (mode_q.unsgn),
    .wdata      (wdata_q),
    .rdata_pair ({hi_q, lo_q}),
    .wide       (wide),
    .smask      (smask),
    .load_data  (load_data)
  );

  // dbus_valid is registered so the BEAT0 -> BEAT1 hop leaves a one-cycle gap.
  always_comb begin
    state_d  = state_q;
    dvalid_d = dvalid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d  = req_reject ? ST_RESP : ST_BEAT0;
          dvalid_d = !req_reject;
        end
      end
      ST_BEAT0: begin
        if (beat_done) begin
          state_d  = cross_q ? ST_BEAT1 : ST_RESP;
          dvalid_d = 1'b0;
        end
      end
      ST_BEAT1: begin
        if (beat_done) begin
          state_d  = ST_RESP;
          dvalid_d = 1'b0;
        end else if (!dvalid_q) begin
          dvalid_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dvalid_q <= 1'b0;
      // NOTE: the datapath latches are reset as well so the gated outputs and
      // any abandoned beat leave nothing visible after reset.
      addr_q   <= '0;
      wdata_q  <= '0;
      mode_q   <= '0;
      cross_q  <= 1'b0;
      mis_q    <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      dvalid_q <= dvalid_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        mode_q  <= bus.req_mode;
        cross_q <= req_cross;
        mis_q   <= req_reject;
        lo_q    <= '0;
        hi_q    <= '0;
      end
      if (beat_done) begin
        if (state_q == ST_BEAT0) lo_q <= bus.dbus_rdata;
        else                     hi_q <= bus.dbus_rdata;
      end
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);

  always_comb begin
    bus.dbus_valid      = dvalid_q;
    bus.dbus_addr       = '0;
    bus.dbus_size       = MSIZE_1B;
    bus.dbus_strobe     = '0;
    bus.dbus_wdata      = '0;
    bus.resp_valid      = (state_q == ST_RESP);
    bus.resp_misaligned = (state_q == ST_RESP) && mis_q;
    bus.resp_rdata      = '0;

    if (dvalid_q) begin
      bus.dbus_size = msize_t'(OFFW);
      if (state_q == ST_BEAT1) begin
        bus.dbus_addr   = beat0_addr + XLEN'(BUS_BYTES);
        bus.dbus_strobe = mode_q.store ? smask[2*BUS_BYTES-1:BUS_BYTES] : '0;
        bus.dbus_wdata  = wide[2*BUS_W-1:BUS_W];
      end else begin
        bus.dbus_addr   = beat0_addr;
        bus.dbus_strobe = mode_q.store ? smask[BUS_BYTES-1:0] : '0;
        bus.dbus_wdata  = wide[BUS_W-1:0];
      end
    end

    if ((state_q == ST_RESP) && !mis_q && !mode_q.store) begin
      bus.resp_rdata = load_data;
    end
  end

endmodule
